// File: rtl/vga_dec_pkg.sv
// Shared types and default 640x480@60 raster constants for the VGA sync decoder.
package vga_dec_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } dec_state_t;

    localparam int DEF_H_TOTAL     = 800;
    localparam int DEF_V_TOTAL     = 525;
    localparam int DEF_HD          = 640;
    localparam int DEF_VD          = 480;
    localparam int DEF_H_ACT_START = 144;
    localparam int DEF_V_ACT_START = 35;
    localparam int DEF_LOCK_FRAMES = 2;

    localparam logic [11:0] CNT_MAX = 12'd4095;

    localparam int POL_WIN_W = 20;
    localparam int POL_WIN   = 1 << POL_WIN_W;

    // Counters stick at CNT_MAX so a dead input reads as loss of signal.
    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == CNT_MAX) ? v : v + 12'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with delayed copy and polarity-aware leading-edge pulse.
// The synchronized level is exported only when VGA_DEC_POL_DETECT_EN is defined.
module sync_edge_det (
    input  logic clk_25M,
    input  logic rst_p,
    input  logic sync_in,
    input  logic pol,
`ifdef VGA_DEC_POL_DETECT_EN
    output logic level,
`endif
    output logic lead_edge
);

    logic s1_reg, s2_reg, s3_reg;

    // Reset to the idle level of an active-low sync so release never fakes an edge.
    always_ff @(posedge clk_25M or posedge rst_p) begin
        if (rst_p) begin
            s1_reg <= 1'b1;
            s2_reg <= 1'b1;
            s3_reg <= 1'b1;
        end else begin
            s1_reg <= sync_in;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

`ifdef VGA_DEC_POL_DETECT_EN
    assign level = s2_reg;
`endif
    assign lead_edge = pol ? (s2_reg & ~s3_reg) : (~s2_reg & s3_reg);

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: measures line/frame length, locks, regenerates pixel coords.
// Optional sync polarity detection is enabled by defining VGA_DEC_POL_DETECT_EN.
module vga_sync_decoder
    import vga_dec_pkg::*;
#(
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int HD          = DEF_HD,
    parameter int VD          = DEF_VD,
    parameter int H_ACT_START = DEF_H_ACT_START,
    parameter int V_ACT_START = DEF_V_ACT_START,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic        clk_25M,
    input  logic        rst_p,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [11:0] pixel_x,
    output logic [11:0] pixel_y,
    output logic        video_on,
    output logic        locked,
    output logic        sync_err,
    output logic [11:0] line_len,
    output logic [11:0] frame_lines,
    output logic        h_pol,
    output logic        v_pol
);

    logic [1:0] sync_raw, sync_pol, sync_edge;
`ifdef VGA_DEC_POL_DETECT_EN
    logic [1:0] sync_lvl;
`endif

    assign sync_raw = {vsync_in, hsync_in};

    // Channel 0 is hsync, channel 1 is vsync.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            sync_edge_det u_det (
                .clk_25M   (clk_25M),
                .rst_p     (rst_p),
                .sync_in   (sync_raw[gi]),
                .pol       (sync_pol[gi]),
`ifdef VGA_DEC_POL_DETECT_EN
                .level     (sync_lvl[gi]),
`endif
                .lead_edge (sync_edge[gi])
            );
        end
    endgenerate

    logic        h_edge, v_edge, boundary;
    logic [11:0] h_cnt_reg, v_cnt_reg, line_len_reg, frame_lines_reg;
    logic [11:0] h_len, v_len;
    logic        vs_armed_reg;

    assign h_edge   = sync_edge[0];
    assign v_edge   = sync_edge[1];
    assign h_len    = h_cnt_reg + 12'd1;
    assign v_len    = v_cnt_reg + 12'd1;
    assign boundary = h_edge && (vs_armed_reg || v_edge);

    always_ff @(posedge clk_25M or posedge rst_p) begin
        if (rst_p) begin
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            line_len_reg    <= '0;
            frame_lines_reg <= '0;
            vs_armed_reg    <= 1'b0;
        end else begin
            if (h_edge) begin
                h_cnt_reg    <= '0;
                line_len_reg <= h_len;
            end else begin
                h_cnt_reg <= sat_inc(h_cnt_reg);
            end
            if (boundary) begin
                frame_lines_reg <= v_len;
                v_cnt_reg       <= '0;
                vs_armed_reg    <= 1'b0;
            end else begin
                if (h_edge) v_cnt_reg <= sat_inc(v_cnt_reg);
                if (v_edge) vs_armed_reg <= 1'b1;
            end
        end
    end

    dec_state_t state_reg;
    logic [3:0] good_cnt_reg;
    logic       locked_reg, sync_err_reg;
    logic       line_bad, frame_bad, sig_lost, win_done;

    assign line_bad  = h_edge && (h_len != 12'(H_TOTAL));
    assign frame_bad = boundary && (v_len != 12'(V_TOTAL));
    assign sig_lost  = (h_cnt_reg == CNT_MAX) || (v_cnt_reg == CNT_MAX);

    always_ff @(posedge clk_25M or posedge rst_p) begin
        if (rst_p) begin
            state_reg    <= SEARCH;
            good_cnt_reg <= '0;
            locked_reg   <= 1'b0;
            sync_err_reg <= 1'b0;
        end else begin
            sync_err_reg <= 1'b0;
            if (sig_lost || ((state_reg != SEARCH) && (line_bad || frame_bad))) begin
                state_reg    <= SEARCH;
                locked_reg   <= 1'b0;
                sync_err_reg <= (state_reg == LOCKED);
            end else begin
                case (state_reg)
                    SEARCH: if (boundary && win_done) begin
                        state_reg    <= CHECK;
                        good_cnt_reg <= '0;
                    end
                    CHECK: if (boundary) begin
                        good_cnt_reg <= good_cnt_reg + 4'd1;
                        if (good_cnt_reg + 4'd1 == 4'(LOCK_FRAMES)) begin
                            state_reg  <= LOCKED;
                            locked_reg <= 1'b1;
                        end
                    end
                    LOCKED: ;
                    default: state_reg <= SEARCH;
                endcase
            end
        end
    end

`ifdef VGA_DEC_POL_DETECT_EN
    logic [POL_WIN_W-1:0] win_cnt_reg;
    logic                 win_done_reg, win_last;

    assign win_last = (state_reg == SEARCH) && !win_done_reg && (win_cnt_reg == '1);
    assign win_done = win_done_reg;

    // Clearing outside SEARCH restarts the window on every re-entry.
    always_ff @(posedge clk_25M or posedge rst_p) begin
        if (rst_p) begin
            win_cnt_reg  <= '0;
            win_done_reg <= 1'b0;
        end else if (state_reg != SEARCH) begin
            win_cnt_reg  <= '0;
            win_done_reg <= 1'b0;
        end else if (!win_done_reg) begin
            win_cnt_reg  <= win_cnt_reg + 1'b1;
            win_done_reg <= win_last;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pol
            logic [POL_WIN_W:0] hi_cnt_reg, hi_cnt_next;
            logic               pol_reg;

            assign hi_cnt_next  = hi_cnt_reg + {{POL_WIN_W{1'b0}}, sync_lvl[gi]};
            assign sync_pol[gi] = pol_reg;

            always_ff @(posedge clk_25M or posedge rst_p) begin
                if (rst_p) begin
                    hi_cnt_reg <= '0;
                    pol_reg    <= 1'b0;
                end else if (state_reg != SEARCH) begin
                    hi_cnt_reg <= '0;
                end else if (!win_done_reg) begin
                    hi_cnt_reg <= hi_cnt_next;
                    if (win_last) pol_reg <= (hi_cnt_next > (POL_WIN_W + 1)'(POL_WIN / 2));
                end
            end
        end
    endgenerate
`else
    assign sync_pol = 2'b00;
    assign win_done = 1'b1;
`endif

    logic h_act, v_act;

    assign h_act = (h_cnt_reg >= 12'(H_ACT_START)) && (h_cnt_reg <= 12'(H_ACT_START + HD - 1));
    assign v_act = (v_cnt_reg >= 12'(V_ACT_START)) && (v_cnt_reg <= 12'(V_ACT_START + VD - 1));

    assign video_on    = locked_reg && h_act && v_act;
    assign pixel_x     = video_on ? (h_cnt_reg - 12'(H_ACT_START)) : 12'd0;
    assign pixel_y     = video_on ? (v_cnt_reg - 12'(V_ACT_START)) : 12'd0;
    assign locked      = locked_reg;
    assign sync_err    = sync_err_reg;
    assign line_len    = line_len_reg;
    assign frame_lines = frame_lines_reg;
    assign h_pol       = sync_pol[0];
    assign v_pol       = sync_pol[1];

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder: 800-clock lines with a short 8-line frame.
module tb_vga_sync_decoder;

    localparam int HT = 800;
    localparam int VT = 8;
    localparam int HA = 144;
    localparam int HDW = 640;
    localparam int VA = 3;
    localparam int VDW = 4;
    localparam int HSW = 96;

    logic        clk_25M = 1'b0;
    logic        rst_p = 1'b1;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [11:0] pixel_x, pixel_y, line_len, frame_lines;
    logic        video_on, locked, sync_err, h_pol, v_pol;

    vga_sync_decoder #(
        .H_TOTAL(HT), .V_TOTAL(VT), .HD(HDW), .VD(VDW),
        .H_ACT_START(HA), .V_ACT_START(VA), .LOCK_FRAMES(2)
    ) dut (
        .clk_25M     (clk_25M),
        .rst_p       (rst_p),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .video_on    (video_on),
        .locked      (locked),
        .sync_err    (sync_err),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .h_pol       (h_pol),
        .v_pol       (v_pol)
    );

    always #20 clk_25M = ~clk_25M;

    int errors = 0;
    int checks = 0;

    // Transmit position: frame, line, column of the clock being driven.
    int tx_f = 0, tx_v = 0, tx_c = 0;
    int last_f = 0, last_v = 0, last_c = 0;
    int stretch_line = -1;
    bit hs_kill = 1'b0;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One pixel clock of active-low stream; outputs afterwards reflect the preceding posedge.
    task automatic tick();
        int len;
        @(negedge clk_25M);
        hsync_in = (hs_kill || tx_c >= HSW) ? 1'b1 : 1'b0;
        vsync_in = (tx_v < 2) ? 1'b0 : 1'b1;
        last_f = tx_f; last_v = tx_v; last_c = tx_c;
        len = (tx_v == stretch_line) ? HT + 1 : HT;
        tx_c++;
        if (tx_c >= len) begin
            if (tx_v == stretch_line) stretch_line = -1;
            tx_c = 0;
            tx_v++;
            if (tx_v == VT) begin
                tx_v = 0;
                tx_f++;
            end
        end
    endtask

    task automatic goto(input int f, input int v, input int c);
        int guard = 0;
        do begin
            tick();
            guard++;
        end while (!(last_f == f && last_v == v && last_c == c) && guard < 90000);
        if (guard >= 90000) begin
            checks++;
            errors++;
            $error("FAIL goto_timeout f=%0d v=%0d c=%0d observed=unreached expected=reached", f, v, c);
        end
    endtask

    initial begin
        // Reset held while both syncs toggle.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_25M);
            hsync_in = ~hsync_in;
            vsync_in = (i % 3 == 0) ? ~vsync_in : vsync_in;
        end
        chk("rst_locked", {11'd0, locked}, 12'd0);
        chk("rst_sync_err", {11'd0, sync_err}, 12'd0);
        chk("rst_line_len", line_len, 12'd0);
        chk("rst_frame_lines", frame_lines, 12'd0);
        chk("rst_h_pol", {11'd0, h_pol}, 12'd0);
        chk("rst_v_pol", {11'd0, v_pol}, 12'd0);
        chk("rst_video_on", {11'd0, video_on}, 12'd0);
        chk("rst_pixel_x", pixel_x, 12'd0);
        chk("rst_pixel_y", pixel_y, 12'd0);

        @(negedge clk_25M);
        rst_p = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        repeat (4) @(negedge clk_25M);
        chk("post_rst_locked", {11'd0, locked}, 12'd0);
        chk("post_rst_line_len", line_len, 12'd0);

        // Second boundary: one good frame counted, not yet locked.
        goto(1, 0, 3);
        chk("b2_locked", {11'd0, locked}, 12'd0);
        chk("b2_frame_lines", frame_lines, 12'(VT));

        // Third boundary: lock rises on the counter reload edge.
        goto(2, 0, 2);
        chk("b3_pre_locked", {11'd0, locked}, 12'd0);
        goto(2, 0, 3);
        chk("b3_locked", {11'd0, locked}, 12'd1);
        chk("b3_line_len", line_len, 12'd800);
        chk("b3_frame_lines", frame_lines, 12'(VT));

        // Active window corners (h_cnt trails the driven column by 3).
        goto(2, 2, 147);
        chk("vid_line_above", {11'd0, video_on}, 12'd0);
        goto(2, 3, 146);
        chk("vid_col_before", {11'd0, video_on}, 12'd0);
        chk("vid_col_before_px", pixel_x, 12'd0);
        goto(2, 3, 147);
        chk("vid_first_on", {11'd0, video_on}, 12'd1);
        chk("vid_first_px", pixel_x, 12'd0);
        chk("vid_first_py", pixel_y, 12'd0);
        goto(2, 3, 200);
        chk("vid_mid_px", pixel_x, 12'd53);
        goto(2, 4, 400);
        chk("vid_mid_py", pixel_y, 12'd1);
        goto(2, 6, 786);
        chk("vid_last_on", {11'd0, video_on}, 12'd1);
        chk("vid_last_px", pixel_x, 12'd639);
        chk("vid_last_py", pixel_y, 12'(VDW - 1));
        goto(2, 6, 787);
        chk("vid_h784_off", {11'd0, video_on}, 12'd0);
        chk("vid_h784_px", pixel_x, 12'd0);
        goto(2, 7, 150);
        chk("vid_line_below", {11'd0, video_on}, 12'd0);

        // Stretch line 5 of frame 3 to 801 clocks.
        goto(3, 4, 10);
        stretch_line = 5;
        goto(3, 6, 2);
        chk("str_pre_locked", {11'd0, locked}, 12'd1);
        chk("str_pre_err", {11'd0, sync_err}, 12'd0);
        goto(3, 6, 3);
        chk("str_locked", {11'd0, locked}, 12'd0);
        chk("str_err", {11'd0, sync_err}, 12'd1);
        chk("str_line_len", line_len, 12'd801);
        goto(3, 6, 4);
        chk("str_err_once", {11'd0, sync_err}, 12'd0);

        // Relock: SEARCH->CHECK at frame 4, good frames end at 5 and 6.
        goto(5, 0, 3);
        chk("relock_early", {11'd0, locked}, 12'd0);
        goto(6, 0, 3);
        chk("relock", {11'd0, locked}, 12'd1);
        chk("relock_line_len", line_len, 12'd800);
        chk("relock_err", {11'd0, sync_err}, 12'd0);

        // Loss of hsync: h_cnt reaches 4095 after 4098 clocks, locked drops one clock later.
        goto(6, 2, 0);
        hs_kill = 1'b1;
        repeat (4098) tick();
        chk("los_still_locked", {11'd0, locked}, 12'd1);
        tick();
        chk("los_locked", {11'd0, locked}, 12'd0);
        chk("los_err", {11'd0, sync_err}, 12'd1);
        tick();
        chk("los_err_once", {11'd0, sync_err}, 12'd0);
        chk("los_line_len", line_len, 12'd800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
